// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse decoder: FSM states, timing multipliers
// in Morse units, and the character code/length widths.
package morse_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MARK = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    localparam int unsigned DOT_UNITS  = 1;
    localparam int unsigned DASH_UNITS = 3;
    localparam int unsigned CGAP_UNITS = 3;
    localparam int unsigned WGAP_UNITS = 7;

    localparam int unsigned CODE_W = 8;
    localparam int unsigned LEN_W  = 4;

endpackage

// File: rtl/morse_run_cnt.sv
// Saturating run-length counter: clear loads 1 (the first sample of a new run),
// increment adds one and sticks at all-ones.
module morse_run_cnt #(
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = CNT_W'(1);
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/morse_decoder.sv
// Decodes a serial Morse LED stream into left-aligned dot/dash codes with a symbol
// count; a zero-length output marks a word space.
module morse_decoder
    import morse_pkg::*;
#(
    parameter int unsigned UNIT  = 1,
    parameter int unsigned CNT_W = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              led_drv,
    output logic              char_vald,
    output logic [CODE_W-1:0] charcode_data,
    output logic [LEN_W-1:0]  charlen_data,
    output logic              sym_err
);

    localparam logic [CNT_W-1:0]  DOT_RUN   = CNT_W'(DOT_UNITS * UNIT);
    localparam logic [CNT_W-1:0]  DASH_RUN  = CNT_W'(DASH_UNITS * UNIT);
    localparam logic [CNT_W-1:0]  CGAP_LAST = CNT_W'(CGAP_UNITS * UNIT - 1);
    localparam logic [CNT_W-1:0]  WGAP_LAST = CNT_W'(WGAP_UNITS * UNIT - 1);
    localparam logic [LEN_W-1:0]  LEN_MAX   = LEN_W'(CODE_W);
    localparam logic [CODE_W-1:0] CODE_MSB  = {1'b1, {(CODE_W-1){1'b0}}};

    state_e            state_q;
    logic [CNT_W-1:0]  run_q;
    logic [CODE_W-1:0] code_q, ocode_q;
    logic [LEN_W-1:0]  len_q, olen_q;
    logic              armed_q, drop_q, vald_q, err_q;
    logic              run_clr, is_dot, is_dash, cgap_hit, wgap_hit;

    // A new run starts whenever the sample disagrees with what the state is timing.
    assign run_clr = led_drv ^ (state_q == ST_MARK);

    morse_run_cnt #(.CNT_W(CNT_W)) u_run_cnt (
        .clk_i  (clock),
        .rst_ni (reset),
        .clr_i  (run_clr),
        .inc_i  (!run_clr),
        .cnt_o  (run_q)
    );

    assign is_dot   = (run_q == DOT_RUN);
    assign is_dash  = (run_q == DASH_RUN);
    // Evaluated against the count before this sample, so a mark landing on the
    // character-gap edge still closes the pending character.
    assign cgap_hit = (run_q == CGAP_LAST);
    assign wgap_hit = (run_q == WGAP_LAST) && !led_drv;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            code_q  <= '0;
            len_q   <= '0;
            armed_q <= 1'b0;
            drop_q  <= 1'b0;
            vald_q  <= 1'b0;
            err_q   <= 1'b0;
            ocode_q <= '0;
            olen_q  <= '0;
        end else begin
            vald_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (led_drv) state_q <= ST_MARK;
                end
                ST_MARK: begin
                    if (!led_drv) begin
                        state_q <= ST_GAP;
                        if (!drop_q) begin
                            if ((is_dot || is_dash) && (len_q != LEN_MAX)) begin
                                code_q <= code_q | (is_dash ? (CODE_MSB >> len_q) : '0);
                                len_q  <= len_q + 1'b1;
                            end else begin
                                err_q  <= 1'b1;
                                code_q <= '0;
                                len_q  <= '0;
                                drop_q <= 1'b1;
                            end
                        end
                    end
                end
                ST_GAP: begin
                    if (cgap_hit) begin
                        if (drop_q) begin
                            drop_q <= 1'b0;
                        end else if (len_q != '0) begin
                            vald_q  <= 1'b1;
                            ocode_q <= code_q;
                            olen_q  <= len_q;
                            code_q  <= '0;
                            len_q   <= '0;
                            armed_q <= 1'b1;
                        end
                    end
                    if (led_drv) begin
                        state_q <= ST_MARK;
                    end else if (wgap_hit) begin
                        state_q <= ST_IDLE;
                        if (armed_q) begin
                            vald_q  <= 1'b1;
                            ocode_q <= '0;
                            olen_q  <= '0;
                            armed_q <= 1'b0;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign char_vald     = vald_q;
    assign charcode_data = ocode_q;
    assign charlen_data  = olen_q;
    assign sym_err       = err_q;

endmodule

// File: doc/morse_decoder.md
MORSE_DECODER -- requirements
Module: morse_decoder

Interface
REQ-001 Parameter: UNIT, 1, clock cycles per Morse time unit (dot = 1 unit, dash = 3, intra-character gap = 1, character gap = 3, word gap = 7).
REQ-002 Parameter: CNT_W, 5, width of run-length counter; SHALL hold 7*UNIT+1 without overflow.
REQ-003 clock  input  1  sole clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 led_drv  input  1  serial Morse LED stream from the upstream encoder; high = mark, low = blank.
REQ-006 char_vald  output  1  one-cycle pulse; decoded character or space present on data outputs.
REQ-007 charcode_data  output  8  symbols left-aligned, MSB first, dash = 1, dot = 0, unused LSBs 0.
REQ-008 charlen_data  output  4  symbol count 1..8; 0 denotes a word space.
REQ-009 sym_err  output  1  one-cycle pulse on an illegal mark length or symbol overflow.

Function
REQ-010 led_drv SHALL be sampled once per rising edge; run counter counts consecutive equal samples, saturating at all-ones.
REQ-011 FSM states SHALL be IDLE, MARK, GAP.
REQ-012 IDLE: low sample -> stay; high sample -> MARK, run=1.
REQ-013 MARK: high -> run+1; low -> classify run (==UNIT dot, ==3*UNIT dash, else illegal), -> GAP, run=1.
REQ-014 Legal symbol SHALL be written to code bit 7-len, len+1; a legal symbol arriving when len==8 is illegal.
REQ-015 Illegal mark: sym_err pulse same edge as classification; code/len cleared; drop flag set; further marks ignored until next character gap.
REQ-016 GAP: high sample -> MARK, run=1 (intra-character gap, any length below 3*UNIT).
REQ-017 GAP, low sample, run reaching 3*UNIT with len>0 and drop=0: char_vald pulse; charcode_data/charlen_data updated on that edge; code/len cleared; armed=1.
REQ-018 GAP, run reaching 3*UNIT with drop=1: no pulse; drop cleared; armed unchanged.
REQ-019 GAP, run reaching 7*UNIT with armed=1: char_vald pulse with code 0, len 0; armed=0; -> IDLE.
REQ-020 GAP, run reaching 7*UNIT with armed=0: -> IDLE, no pulse; at most one space per blank stretch of any length.
REQ-021 No space SHALL be emitted before the first decoded character after reset.
REQ-022 charcode_data/charlen_data SHALL hold their last emitted value until the next char_vald.
REQ-023 char_vald and sym_err SHALL never both be high in one cycle; neither is high for more than one consecutive cycle.
REQ-024 A mark beginning exactly on the edge run would reach 3*UNIT SHALL be treated as a new character start; the pending character is emitted on that same edge.

Reset
REQ-025 reset low SHALL immediately force: state IDLE, run 0, code 0, len 0, armed 0, drop 0, char_vald 0, charcode_data 0, charlen_data 0, sym_err 0.
REQ-026 Reset asserted mid-character SHALL discard it; no pulse after release until a fresh complete character.
REQ-027 First sample after reset release SHALL be decoded normally.

Structure
REQ-028 Package morse_pkg SHALL hold the FSM state enum, unit multipliers (DOT 1, DASH 3, CGAP 3, WGAP 7), code/length widths (8, 4).
REQ-029 One sub-module morse_run_cnt SHALL implement the saturating run-length counter with clear-to-1 and increment inputs.
REQ-030 Symbol assembly, flags and output registers SHALL reside in morse_decoder; all outputs registered.

Verification (UNIT=1)
REQ-031 led 1,1,1,0,1,1,1,0,0,0 ('M') -> one char_vald, code 1100_0000, len 2.
REQ-032 led 1,0 then 20 lows ('E' + idle) -> char_vald code 0000_0000 len 1 on 3rd low; space pulse (len 0) on 7th low; no further pulses.
REQ-033 '1' (.----) then '6' (-....) separated by 3 lows -> code 0111_1000 len 5, then 1000_0000 len 5.
REQ-034 mark of 2 cycles, then 3 lows -> sym_err pulse, no char_vald; nine dots -> sym_err on ninth, no char_vald.
REQ-035 reset low during a dash, release, then 1,1,1,0,0,0 ('T') -> outputs 0 during reset, single char_vald code 1000_0000 len 1.
REQ-036 loopback from the upstream encoder sending "M16 TA FATIMA" -> 13 pulses matching the ASCII-Morse table, spaces as len 0.
